// File: rtl/tdc_therm2bin_pipe_if.sv
// tdc_therm2bin_pipe_if
//   Bundles the sample input and encoded result of the thermometer-to-binary
//   pipeline.
//
//   Handshake: valid-only, no ready. A sample is accepted on every rising
//   clk edge where in_valid=1, and the sink can never stall the producer.
//   out_valid is a one-cycle pulse per accepted sample. index/err_none/err_multi
//   are meaningful in that cycle and hold their value between pulses.
//
//   Signals: therm_in[TAPS], in_valid, index[IDX_W], out_valid, err_none,
//   err_multi. With TDC_T2B_ERRCNT_EN defined, it also carries err_clr and
//   err_cnt[16].
//   Modports: master = sampler side (drives therm_in/in_valid),
//             slave  = encoder side.
interface tdc_therm2bin_pipe_if #(
  parameter int TAPS  = 195,
  parameter int IDX_W = 8
);
  logic [TAPS-1:0]  therm_in;
  logic             in_valid;
  logic [IDX_W-1:0] index;
  logic             out_valid;
  logic             err_none;
  logic             err_multi;
`ifdef TDC_T2B_ERRCNT_EN
  logic             err_clr;
  logic [15:0]      err_cnt;

  modport master (output therm_in, in_valid, err_clr,
                  input  index, out_valid, err_none, err_multi, err_cnt);
  modport slave  (input  therm_in, in_valid, err_clr,
                  output index, out_valid, err_none, err_multi, err_cnt);
`else
  modport master (output therm_in, in_valid,
                  input  index, out_valid, err_none, err_multi);
  modport slave  (input  therm_in, in_valid,
                  output index, out_valid, err_none, err_multi);
`endif
endinterface

// File: rtl/tdc_therm2bin_pipe.sv
// tdc_therm2bin_pipe
//   Three-stage pipelined thermometer-to-binary encoder for the TDC
//   delay-line sampler.
//     S1: capture therm_in (held when in_valid=0).
//     S2: 3-input majority bubble filter, then 1->0 edge extraction.
//     S3: OR-based encode of the edge position, zero-hit and multi-edge flags.
//   Full throughput with no backpressure. A sample presented in cycle c gives
//   out_valid in cycle c+3.
//
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - tdc_therm2bin_pipe_if.slave (therm_in, in_valid, index,
//             out_valid, err_none, err_multi [, err_clr, err_cnt])
//   Parameters: TAPS (>=4), IDX_W (2**IDX_W >= TAPS), DIRECTION "LSB0"/"MSB0".
//   Optional macro TDC_T2B_ERRCNT_EN adds a saturating 16-bit error counter
//   (err_cnt) with a synchronous clear (err_clr).
module tdc_therm2bin_pipe #(
  parameter int TAPS      = 195,
  parameter int IDX_W     = 8,
  parameter     DIRECTION = "LSB0"
) (
  input  logic                clk,
  input  logic                rst_n,
  tdc_therm2bin_pipe_if.slave bus
);

  localparam bit MSB0 = (DIRECTION == "MSB0");

  // S1
  logic [TAPS-1:0] t_r;
  logic            v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r <= '0;
      v1  <= 1'b0;
    end else begin
      if (bus.in_valid) t_r <= bus.therm_in;
      v1 <= bus.in_valid;
    end
  end

  // S2: tp pads t_r with the virtual taps t_r[-1]=1 (below) and t_r[TAPS]=0
  // (above), so the lower and upper neighbours of every tap are plain slices.
  logic [TAPS+1:0] tp;
  logic [TAPS-1:0] nb_lo, nb_hi, m, e;
  logic [TAPS-1:0] e_r;
  logic            v2;

  always_comb begin
    tp    = {1'b0, t_r, 1'b1};
    nb_lo = tp[TAPS-1:0];
    nb_hi = tp[TAPS+1:2];
    m     = (nb_lo & t_r) | (nb_lo & nb_hi) | (t_r & nb_hi);
    // The edge sits on the last filtered one; m[TAPS] is taken as 0.
    e     = m & ~{1'b0, m[TAPS-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_r <= '0;
      v2  <= 1'b0;
    end else begin
      e_r <= e;
      v2  <= v1;
    end
  end

  // S3: the index is the OR of the positions of all set edge bits. With a
  // single edge this is exact, and with several it is defined but flagged.
  // "seen" tracks whether any lower edge bit is set, so multi catches any pair.
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] idx_next;
  logic             seen;
  logic             multi;

  always_comb begin
    k     = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (e_r[i]) k = k | IDX_W'(i);
      multi = multi | (seen & e_r[i]);
      seen  = seen | e_r[i];
    end
    idx_next = MSB0 ? (IDX_W'(TAPS - 1) - k) : k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.index     <= '0;
      bus.err_none  <= 1'b0;
      bus.err_multi <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.index     <= idx_next;
        bus.err_none  <= ~seen;
        bus.err_multi <= multi;
      end
    end
  end

`ifdef TDC_T2B_ERRCNT_EN
  // Counts result cycles that carry an error, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_cnt <= '0;
    end else if (bus.err_clr) begin
      bus.err_cnt <= '0;
    end else if (bus.out_valid && (bus.err_none || bus.err_multi) &&
                 (bus.err_cnt != 16'hFFFF)) begin
      bus.err_cnt <= bus.err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdc_therm2bin_pipe.sv
module tb_tdc_therm2bin_pipe;
  localparam int TAPS  = 195;
  localparam int IDX_W = 8;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_therm2bin_pipe_if #(.TAPS(TAPS), .IDX_W(IDX_W)) bus ();
  tdc_therm2bin_pipe_if #(.TAPS(TAPS), .IDX_W(IDX_W)) busm ();

  tdc_therm2bin_pipe #(.TAPS(TAPS), .IDX_W(IDX_W), .DIRECTION("LSB0")) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  tdc_therm2bin_pipe #(.TAPS(TAPS), .IDX_W(IDX_W), .DIRECTION("MSB0")) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busm)
  );

  // scoreboard: {index, err_none, err_multi}, MSB0 index, due cycle
  logic [9:0]       exp_q[$];
  logic [IDX_W-1:0] exp_m_q[$];
  int               cyc_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TAPS-1:0] ones(input int k);
    logic [TAPS-1:0] t;
    t = '0;
    for (int i = 0; i <= k; i++) t[i] = 1'b1;
    return t;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic send(input logic [TAPS-1:0] t, input int k, input bit none, input bit multi);
    logic [IDX_W-1:0] ki;
    ki = IDX_W'(k);
    bus.therm_in  = t;
    busm.therm_in = t;
    bus.in_valid  = 1'b1;
    busm.in_valid = 1'b1;
    exp_q.push_back({ki, none, multi});
    exp_m_q.push_back(IDX_W'(TAPS - 1) - ki);
    cyc_q.push_back(cyc + 3);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    busm.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    busm.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // monitor
  logic [IDX_W-1:0] last_idx, last_idx_m;
  logic             last_none, last_multi;
  logic [9:0]       e;
  logic [IDX_W-1:0] em;
  int               c;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_index", bus.index, 0);
      chk("rst_err_none", bus.err_none, 0);
      chk("rst_err_multi", bus.err_multi, 0);
      chk("rst_msb0_out_valid", busm.out_valid, 0);
      chk("rst_msb0_index", busm.index, 0);
`ifdef TDC_T2B_ERRCNT_EN
      chk("rst_err_cnt", bus.err_cnt, 0);
`endif
      last_idx   <= '0;
      last_idx_m <= '0;
      last_none  <= 1'b0;
      last_multi <= 1'b0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", bus.out_valid, 0);
      end else begin
        e  = exp_q.pop_front();
        em = exp_m_q.pop_front();
        c  = cyc_q.pop_front();
        chk("latency_cycle", cyc, c);
        chk("index", bus.index, e[9:2]);
        chk("err_none", bus.err_none, e[1]);
        chk("err_multi", bus.err_multi, e[0]);
        chk("msb0_out_valid", busm.out_valid, 1);
        chk("msb0_index", busm.index, em);
      end
      last_idx   <= bus.index;
      last_idx_m <= busm.index;
      last_none  <= bus.err_none;
      last_multi <= bus.err_multi;
    end else begin
      chk("hold_index", bus.index, last_idx);
      chk("hold_err_none", bus.err_none, last_none);
      chk("hold_err_multi", bus.err_multi, last_multi);
      chk("hold_msb0_index", busm.index, last_idx_m);
      if (cyc_q.size() != 0 && cyc_q[0] <= cyc) begin
        chk("missing_out_valid", bus.out_valid, 1);
        void'(exp_q.pop_front());
        void'(exp_m_q.pop_front());
        void'(cyc_q.pop_front());
      end
    end
  end

  // stimulus
  logic [TAPS-1:0] t;

  initial begin
    bus.therm_in  = '0;
    bus.in_valid  = 1'b0;
    busm.therm_in = '0;
    busm.in_valid = 1'b0;
`ifdef TDC_T2B_ERRCNT_EN
    bus.err_clr   = 1'b0;
    busm.err_clr  = 1'b0;
`endif
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // basic latency, bits[41:0]
    send(ones(41), 41, 1'b0, 1'b0);
    idle(5);

    // boundaries
    send('1, 194, 1'b0, 1'b0);
    send('0, 0, 1'b1, 1'b0);
    idle(4);

    // bubbles: single removed, double gives edges at 49 and 99 (49|99 = 115)
    t = ones(99); t[50] = 1'b0;
    send(t, 99, 1'b0, 1'b0);
    t = ones(99); t[50] = 1'b0; t[51] = 1'b0;
    send(t, 115, 1'b0, 1'b1);
    idle(4);

    // throughput: edges 0..9 back to back
    for (int k = 0; k < 10; k++) send(ones(k), k, 1'b0, 1'b0);
    idle(1);
    // gap between samples
    send(ones(20), 20, 1'b0, 1'b0);
    idle(2);
    send(ones(30), 30, 1'b0, 1'b0);
    idle(5);

    // reset one cycle after in_valid: sample must be dropped
    send(ones(60), 60, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_m_q.delete();
    cyc_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(8);
    send(ones(10), 10, 1'b0, 1'b0);
    idle(5);

`ifdef TDC_T2B_ERRCNT_EN
    bus.err_clr = 1'b1; busm.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0; busm.err_clr = 1'b0;
    for (int n = 0; n < 3; n++) send('0, 0, 1'b1, 1'b0);
    idle(6);
    chk("err_cnt_three", bus.err_cnt, 3);
    bus.err_clr = 1'b1; busm.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0; busm.err_clr = 1'b0;
    chk("err_cnt_clear", bus.err_cnt, 0);
    for (int n = 0; n < 65537; n++) send('0, 0, 1'b1, 1'b0);
    idle(6);
    chk("err_cnt_saturate", bus.err_cnt, 16'hFFFF);
    chk("err_cnt_saturate_msb0", busm.err_cnt, 16'hFFFF);
`endif

    idle(6);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
